// File: rtl/frame_render_monitor.sv
// frame_render_monitor
//   Passive per-frame monitor for the ray_marcher pixel stream. It measures
//   the render time of each frame, counts and checksums the in-range pixels,
//   builds a colour histogram and flags range and raster-order errors. All
//   results are latched at each new_frame_in boundary.
// Ports
//   clk_in, rst_in             clock, asynchronous active-low reset
//   hcount_in, vcount_in       pixel column / row
//   color_in, valid_in         pixel colour and qualifier
//   new_frame_in               one-cycle pulse: previous frame done, next starts
//   stats_valid_out            one-cycle pulse when the stats below update
//   frame_cycles_out           cycles between the last two frame pulses (saturating)
//   pixel_count_out            in-range pixels accepted in the last frame
//   checksum_out               order-independent sum of {v,h,colour}
//   complete_out               exactly W*H pixels with no range/order error
//   range_err_out              last frame carried an out-of-range pixel
//   order_err_out              last frame broke raster order (ORDERED=1 only)
//   frame_count_out            frames latched since reset (wraps)
//   hist_addr_in/hist_data_out registered histogram read of the last frame
module frame_render_monitor #(
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 240,
  parameter int H_BITS         = 9,
  parameter int V_BITS         = 8,
  parameter int COLOR_BITS     = 4,
  parameter int CYC_BITS       = 32,
  parameter int ORDERED        = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [H_BITS-1:0]     hcount_in,
  input  logic [V_BITS-1:0]     vcount_in,
  input  logic [COLOR_BITS-1:0] color_in,
  input  logic                  valid_in,
  input  logic                  new_frame_in,
  output logic                  stats_valid_out,
  output logic [CYC_BITS-1:0]   frame_cycles_out,
  output logic [31:0]           pixel_count_out,
  output logic [31:0]           checksum_out,
  output logic                  complete_out,
  output logic                  range_err_out,
  output logic                  order_err_out,
  output logic [15:0]           frame_count_out,
  input  logic [COLOR_BITS-1:0] hist_addr_in,
  output logic [31:0]           hist_data_out
);

  localparam int NBINS = 2 ** COLOR_BITS;
  localparam logic [H_BITS:0] W_EXT    = (H_BITS+1)'(DISPLAY_WIDTH);
  localparam logic [V_BITS:0] H_EXT    = (V_BITS+1)'(DISPLAY_HEIGHT);
  localparam logic [31:0]     PIX_FULL = 32'(DISPLAY_WIDTH * DISPLAY_HEIGHT);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [CYC_BITS-1:0] cyc_acc, cyc_nxt;
  logic [31:0]         pix_acc, pix_nxt, csum_acc, csum_nxt;
  logic                range_err_acc, range_nxt, order_err_acc, order_nxt;
  logic [H_BITS-1:0]   exp_h, exp_h_base, exp_h_nxt;
  logic [V_BITS-1:0]   exp_v, exp_v_base, exp_v_nxt;
  logic                live, frame_end, in_range, accept, mismatch;
  logic                bank_act, bank_wr, bank_rd;
  logic [31:0]         bin_cur, bin_nxt;
  logic [31:0]         hist [0:1][0:NBINS-1];

  // A pixel arriving with new_frame_in belongs to the new frame, so every
  // accumulator is built from a cleared base in that cycle before adding it.
  always_comb begin
    state_nxt  = state;
    live       = (state == RUN) || new_frame_in;
    frame_end  = (state == RUN) && new_frame_in;
    in_range   = ({1'b0, hcount_in} < W_EXT) && ({1'b0, vcount_in} < H_EXT);
    accept     = live && valid_in && in_range;
    exp_h_base = new_frame_in ? '0 : exp_h;
    exp_v_base = new_frame_in ? '0 : exp_v;
    mismatch   = accept && ((hcount_in != exp_h_base) || (vcount_in != exp_v_base));
    if (state == IDLE && new_frame_in) state_nxt = RUN;

    if (new_frame_in)        cyc_nxt = CYC_BITS'(1);
    else if (cyc_acc == '1)  cyc_nxt = cyc_acc;
    else                     cyc_nxt = cyc_acc + 1'b1;

    pix_nxt   = new_frame_in ? '0 : pix_acc;
    csum_nxt  = new_frame_in ? '0 : csum_acc;
    range_nxt = ~new_frame_in & range_err_acc;
    order_nxt = (ORDERED != 0) && ((~new_frame_in & order_err_acc) | mismatch);
    if (accept) begin
      if (pix_nxt != '1) pix_nxt = pix_nxt + 1'b1;
      csum_nxt = csum_nxt + 32'({vcount_in, hcount_in, color_in});
    end
    if (live && valid_in && !in_range) range_nxt = 1'b1;

    // Expected position resyncs to the accepted pixel + 1 in raster order.
    exp_h_nxt = exp_h_base;
    exp_v_nxt = exp_v_base;
    if (accept) begin
      if (({1'b0, hcount_in} + 1'b1) == W_EXT) begin
        exp_h_nxt = '0;
        exp_v_nxt = (({1'b0, vcount_in} + 1'b1) == H_EXT) ? '0 : vcount_in + 1'b1;
      end else begin
        exp_h_nxt = hcount_in + 1'b1;
        exp_v_nxt = vcount_in;
      end
    end

    bank_wr = frame_end ? ~bank_act : bank_act;
    bank_rd = ~bank_act;
    bin_cur = hist[bank_wr][color_in];
    if (new_frame_in)        bin_nxt = 32'd1;
    else if (bin_cur == '1)  bin_nxt = bin_cur;
    else                     bin_nxt = bin_cur + 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= IDLE;
      cyc_acc          <= '0;
      pix_acc          <= '0;
      csum_acc         <= '0;
      range_err_acc    <= 1'b0;
      order_err_acc    <= 1'b0;
      exp_h            <= '0;
      exp_v            <= '0;
      bank_act         <= 1'b0;
      stats_valid_out  <= 1'b0;
      frame_cycles_out <= '0;
      pixel_count_out  <= '0;
      checksum_out     <= '0;
      complete_out     <= 1'b0;
      range_err_out    <= 1'b0;
      order_err_out    <= 1'b0;
      frame_count_out  <= '0;
      hist_data_out    <= '0;
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned i = 0; i < NBINS; i++)
          hist[1'(b)][COLOR_BITS'(i)] <= '0;
    end else begin
      state           <= state_nxt;
      stats_valid_out <= frame_end;
      if (frame_end) begin
        frame_cycles_out <= cyc_acc;
        pixel_count_out  <= pix_acc;
        checksum_out     <= csum_acc;
        complete_out     <= (pix_acc == PIX_FULL) && !range_err_acc && !order_err_acc;
        range_err_out    <= range_err_acc;
        order_err_out    <= order_err_acc;
        frame_count_out  <= frame_count_out + 1'b1;
        bank_act         <= ~bank_act;
      end
      if (live) begin
        cyc_acc       <= cyc_nxt;
        pix_acc       <= pix_nxt;
        csum_acc      <= csum_nxt;
        range_err_acc <= range_nxt;
        order_err_acc <= order_nxt;
        exp_h         <= exp_h_nxt;
        exp_v         <= exp_v_nxt;
      end
      if (new_frame_in)
        for (int unsigned i = 0; i < NBINS; i++)
          hist[bank_wr][COLOR_BITS'(i)] <= '0;
      if (accept) hist[bank_wr][color_in] <= bin_nxt;
      hist_data_out <= hist[bank_rd][hist_addr_in];
    end
  end

endmodule

// File: tb/tb_frame_render_monitor.sv
module tb_frame_render_monitor;

  typedef struct {
    logic [7:0]  cyc;
    logic [31:0] pix;
    logic [31:0] csum;
    logic        comp;
    logic        rerr;
    logic        oerr;
    logic [15:0] fc;
  } stats_t;

  typedef struct {
    int          tick;
    logic [31:0] val;
  } hist_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] hc = '0;
  logic [7:0] vc = '0;
  logic [3:0] col = '0;
  logic       vld = 1'b0;
  logic       nf = 1'b0;
  logic [3:0] haddr = '0;

  logic        o_sv, o_comp, o_rerr, o_oerr, a_sv, a_comp, a_rerr, a_oerr;
  logic [7:0]  o_fcyc, a_fcyc;
  logic [31:0] o_pix, o_csum, o_hist, a_pix, a_csum, a_hist;
  logic [15:0] o_fc, a_fc;

  int errors = 0;
  int checks = 0;
  int tick = 0;
  int last_nf = 0;
  stats_t q_o[$];
  stats_t q_a[$];
  hist_t  hq[$];

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  frame_render_monitor #(
    .DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(3), .H_BITS(9), .V_BITS(8),
    .COLOR_BITS(4), .CYC_BITS(8), .ORDERED(1)
  ) u_ord (
    .clk_in(clk), .rst_in(rst_n), .hcount_in(hc), .vcount_in(vc), .color_in(col),
    .valid_in(vld), .new_frame_in(nf), .stats_valid_out(o_sv),
    .frame_cycles_out(o_fcyc), .pixel_count_out(o_pix), .checksum_out(o_csum),
    .complete_out(o_comp), .range_err_out(o_rerr), .order_err_out(o_oerr),
    .frame_count_out(o_fc), .hist_addr_in(haddr), .hist_data_out(o_hist)
  );

  frame_render_monitor #(
    .DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(3), .H_BITS(9), .V_BITS(8),
    .COLOR_BITS(4), .CYC_BITS(8), .ORDERED(0)
  ) u_any (
    .clk_in(clk), .rst_in(rst_n), .hcount_in(hc), .vcount_in(vc), .color_in(col),
    .valid_in(vld), .new_frame_in(nf), .stats_valid_out(a_sv),
    .frame_cycles_out(a_fcyc), .pixel_count_out(a_pix), .checksum_out(a_csum),
    .complete_out(a_comp), .range_err_out(a_rerr), .order_err_out(a_oerr),
    .frame_count_out(a_fc), .hist_addr_in(haddr), .hist_data_out(a_hist)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: stats are compared whenever a DUT pulses stats_valid,
  // histogram reads when their scheduled cycle arrives.
  always @(negedge clk) begin
    stats_t e;
    hist_t  h;
    if (rst_n) begin
      if (o_sv) begin
        if (q_o.size() == 0) begin
          checks++; errors++;
          $display("FAIL ord_unexpected_stats: got pulse, required none");
        end else begin
          e = q_o.pop_front();
          cmp("ord frame_cycles", 32'(o_fcyc), 32'(e.cyc));
          cmp("ord pixel_count", o_pix, e.pix);
          cmp("ord checksum", o_csum, e.csum);
          cmp("ord complete", 32'(o_comp), 32'(e.comp));
          cmp("ord range_err", 32'(o_rerr), 32'(e.rerr));
          cmp("ord order_err", 32'(o_oerr), 32'(e.oerr));
          cmp("ord frame_count", 32'(o_fc), 32'(e.fc));
        end
      end
      if (a_sv) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL any_unexpected_stats: got pulse, required none");
        end else begin
          e = q_a.pop_front();
          cmp("any frame_cycles", 32'(a_fcyc), 32'(e.cyc));
          cmp("any pixel_count", a_pix, e.pix);
          cmp("any checksum", a_csum, e.csum);
          cmp("any complete", 32'(a_comp), 32'(e.comp));
          cmp("any range_err", 32'(a_rerr), 32'(e.rerr));
          cmp("any order_err", 32'(a_oerr), 32'(e.oerr));
          cmp("any frame_count", 32'(a_fc), 32'(e.fc));
        end
      end
      while (hq.size() > 0 && hq[0].tick < tick) begin
        h = hq.pop_front();
        checks++; errors++;
        $display("FAIL hist_missed: read scheduled at tick %0d not sampled", h.tick);
      end
      if (hq.size() > 0 && hq[0].tick == tick) begin
        h = hq.pop_front();
        cmp("ord hist_data", o_hist, h.val);
        cmp("any hist_data", a_hist, h.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    vld = 1'b0;
    nf  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pix(input int h, input int v, input int c);
    step();
    vld = 1'b1;
    hc  = 9'(h);
    vc  = 8'(v);
    col = 4'(c);
  endtask

  task automatic hist_rd(input int a, input logic [31:0] exp);
    hist_t h;
    step();
    haddr  = 4'(a);
    h.tick = tick + 1;
    h.val  = exp;
    hq.push_back(h);
  endtask

  function automatic stats_t mk(input int p, input int cs, input bit cp,
                                input bit re, input bit oe, input int f);
    stats_t s;
    s.cyc = '0; s.pix = 32'(p); s.csum = 32'(cs);
    s.comp = cp; s.rerr = re; s.oerr = oe; s.fc = 16'(f);
    return s;
  endfunction

  // Frame pulse; when 'expect_stats' the frame it closes is scored, with the
  // expected cycle count taken from the distance to the previous pulse.
  task automatic frame(input bit expect_stats, input stats_t eo, input stats_t ea,
                       input bit pv, input int h, input int v, input int c);
    int d;
    step();
    nf = 1'b1;
    if (pv) begin
      vld = 1'b1; hc = 9'(h); vc = 8'(v); col = 4'(c);
    end
    if (expect_stats) begin
      d = tick - last_nf;
      eo.cyc = (d > 255) ? 8'd255 : 8'(d);
      ea.cyc = eo.cyc;
      q_o.push_back(eo);
      q_a.push_back(ea);
    end
    last_nf = tick;
  endtask

  // 12 pixels in raster order; colour = h when c < 0, else fixed colour c.
  task automatic raster(input int c, input int first);
    for (int i = first; i < 12; i++) pix(i % 4, i / 4, (c < 0) ? (i % 4) : c);
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    cmp({tag, " ord stats_valid"}, 32'(o_sv), 0);
    cmp({tag, " ord frame_cycles"}, 32'(o_fcyc), 0);
    cmp({tag, " ord pixel_count"}, o_pix, 0);
    cmp({tag, " ord checksum"}, o_csum, 0);
    cmp({tag, " ord flags"}, {29'd0, o_comp, o_rerr, o_oerr}, 0);
    cmp({tag, " ord frame_count"}, 32'(o_fc), 0);
    cmp({tag, " ord hist_data"}, o_hist, 0);
    cmp({tag, " any frame_count"}, 32'(a_fc), 0);
    cmp({tag, " any pixel_count"}, a_pix, 0);
  endtask

  stats_t none;

  initial begin
    none = mk(0, 0, 0, 0, 0, 0);
    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      step();
      hc = 9'($urandom_range(0, 511)); vc = 8'($urandom_range(0, 255));
      col = 4'($urandom); vld = 1'($urandom); nf = 1'($urandom);
      haddr = 4'($urandom);
      chk_reset_outputs("reset");
    end
    step();
    rst_n = 1'b1;
    haddr = '0;
    // Unarmed: pixels are ignored and nothing is latched.
    pix(0, 0, 1); pix(1, 0, 2); pix(2, 0, 3);
    idle(3);

    // F1: ordered frame, colour = h; closed by a pulse 101 cycles later.
    frame(0, none, none, 0, 0, 0, 0);
    raster(-1, 0);
    idle(88);
    frame(1, mk(12, 98610, 1, 0, 0, 1), mk(12, 98610, 1, 0, 0, 1), 0, 0, 0, 0);
    hist_rd(0, 3); hist_rd(1, 3); hist_rd(2, 3); hist_rd(3, 3); hist_rd(5, 0);

    // F2: (1,0) and (2,0) swapped.
    for (int i = 0; i < 12; i++) begin
      int j;
      j = (i == 1) ? 2 : (i == 2) ? 1 : i;
      pix(j % 4, j / 4, j % 4);
    end
    frame(1, mk(12, 98610, 0, 0, 1, 2), mk(12, 98610, 1, 0, 0, 2), 0, 0, 0, 0);

    // F3: full frame plus out-of-range pixel (4,0).
    raster(-1, 0);
    pix(4, 0, 0);
    frame(1, mk(12, 98610, 0, 1, 0, 3), mk(12, 98610, 0, 1, 0, 3), 0, 0, 0, 0);

    // F4: full frame plus duplicate (0,0); the closing pulse carries pixel
    // (0,0,colour 7) which belongs to F5.
    raster(-1, 0);
    pix(0, 0, 0);
    frame(1, mk(13, 98610, 0, 0, 0, 4), mk(13, 98610, 0, 0, 0, 4), 1, 0, 0, 7);

    // F5: remaining 11 pixels in colour 7; mid-frame reads still see F4.
    raster(7, 1);
    hist_rd(0, 4); hist_rd(7, 0); hist_rd(1, 3);
    frame(1, mk(12, 98676, 1, 0, 0, 5), mk(12, 98676, 1, 0, 0, 5), 0, 0, 0, 0);
    // Read issued in the swap cycle: old bank first, new bank one cycle later.
    begin
      hist_t h;
      haddr  = 4'd7;
      h.tick = tick + 1;
      h.val  = 32'd0;
      hq.push_back(h);
    end
    hist_rd(7, 12);
    hist_rd(0, 0);

    // F6 partial, then asynchronous reset mid-frame.
    pix(0, 0, 1); pix(1, 0, 1);
    step();
    rst_n = 1'b0;
    chk_reset_outputs("midreset");
    step();
    chk_reset_outputs("midreset2");
    step();
    rst_n = 1'b1;
    idle(2);

    // Restart: first pulse only arms; long frame saturates the 8-bit counter.
    frame(0, none, none, 0, 0, 0, 0);
    pix(0, 0, 1); pix(1, 0, 1); pix(2, 0, 1);
    idle(300);
    frame(1, mk(3, 51, 0, 0, 0, 1), mk(3, 51, 0, 0, 0, 1), 0, 0, 0, 0);
    hist_rd(1, 3);
    idle(5);

    cmp("ord stats queue drained", q_o.size(), 0);
    cmp("any stats queue drained", q_a.size(), 0);
    cmp("hist queue drained", hq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
